// File: rtl/sweep_seq_ctrl_if.sv
// Sweep job configuration bus: valid/ready handshake plus the job fields
// (bounds, endpoint dwell, half-sweep count) offered to the sweep controller.
interface sweep_seq_if #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int SWEEP_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [WIDTH-1:0]   cfg_lo;
    logic [WIDTH-1:0]   cfg_hi;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [SWEEP_W-1:0] cfg_sweeps;

    // Job source side
    modport master (
        output cfg_valid,
        output cfg_lo,
        output cfg_hi,
        output cfg_dwell,
        output cfg_sweeps,
        input  cfg_ready
    );

    // Controller side
    modport slave (
        input  cfg_valid,
        input  cfg_lo,
        input  cfg_hi,
        input  cfg_dwell,
        input  cfg_sweeps,
        output cfg_ready
    );
endinterface

// File: rtl/sweep_seq_ctrl.sv
// Triangle sweep controller: accepts a job (lo, hi, dwell, half-sweep count),
// steps out lo->hi->lo... holding 1+dwell cycles at each endpoint, with
// pause/abort and a done pulse when the programmed half-sweeps complete.
// Illegal bounds (lo >= hi) are rejected with a one-cycle err pulse.
module sweep_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int SWEEP_W = 8
) (
    input  logic             clk,
    input  logic             reset,     // synchronous, active-low
    sweep_seq_if.slave       cfg,
    input  logic             pause_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] out_o,
    output logic             dir_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
    logic [SWEEP_W-1:0] half_q, half_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

    logic [WIDTH-1:0]   out_inc;
    logic [WIDTH-1:0]   out_dec;
    logic [SWEEP_W-1:0] half_inc;
    logic               last_half;

    // Next-state and output decode; every field defaults to holding its value.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        dir_d       = dir_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        dwell_d     = dwell_q;
        sweeps_d    = sweeps_q;
        half_d      = half_q;
        dwell_cnt_d = dwell_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        out_inc   = out_q + WIDTH'(1);
        out_dec   = out_q - WIDTH'(1);
        half_inc  = half_q + SWEEP_W'(1);
        // sweeps==0 means run forever, so the finishing test never fires then
        last_half = (sweeps_q != '0) && (half_inc == sweeps_q);

        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    if (cfg.cfg_lo >= cfg.cfg_hi) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d     = cfg.cfg_lo;
                        hi_d     = cfg.cfg_hi;
                        dwell_d  = cfg.cfg_dwell;
                        sweeps_d = cfg.cfg_sweeps;
                        out_d    = cfg.cfg_lo;
                        dir_d    = 1'b0;
                        half_d   = '0;
                        state_d  = UP;
                    end
                end
            end
            default: begin
                if (abort_i) begin
                    // abort wins over pause; out is left where it stopped
                    state_d = IDLE;
                    dir_d   = 1'b0;
                end else if (!pause_i) begin
                    case (state_q)
                        UP: begin
                            out_d = out_inc;
                            if (out_inc == hi_q) begin
                                if (last_half) begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                    dir_d   = 1'b0;
                                end else begin
                                    half_d = half_inc;
                                    dir_d  = 1'b1;
                                    if (dwell_q == '0) begin
                                        state_d = DOWN;
                                    end else begin
                                        dwell_cnt_d = dwell_q;
                                        state_d     = HOLD_HI;
                                    end
                                end
                            end
                        end
                        DOWN: begin
                            out_d = out_dec;
                            if (out_dec == lo_q) begin
                                if (last_half) begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                    dir_d   = 1'b0;
                                end else begin
                                    half_d = half_inc;
                                    dir_d  = 1'b0;
                                    if (dwell_q == '0) begin
                                        state_d = UP;
                                    end else begin
                                        dwell_cnt_d = dwell_q;
                                        state_d     = HOLD_LO;
                                    end
                                end
                            end
                        end
                        // The turn-around state itself adds the final endpoint
                        // cycle, so leaving at count 1 gives 1+dwell in total.
                        HOLD_HI: begin
                            if (dwell_cnt_q == DWELL_W'(1)) begin
                                state_d = DOWN;
                            end else begin
                                dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                            end
                        end
                        HOLD_LO: begin
                            if (dwell_cnt_q == DWELL_W'(1)) begin
                                state_d = UP;
                            end else begin
                                dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State and output registers; active-low reset overrides everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_q       <= '0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= '0;
            sweeps_q    <= '0;
            half_q      <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            dwell_q     <= dwell_d;
            sweeps_q    <= sweeps_d;
            half_q      <= half_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign out_o         = out_q;
    assign dir_o         = dir_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign cfg.cfg_ready = ready_q;

endmodule
